// File: rtl/fifo_sync_param.sv
// Parametrised synchronous circular-buffer FIFO for the UART datapath.
// Provides occupancy, programmable almost flags, error pulses, flush, and same-cycle load/read.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk_fifo_i,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       load,
  input  logic                       read,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       LD_fifo_done,
  output logic                       RD_fifo_done,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = read & ~empty;
  assign wr_acc = load & (~full | rd_acc);

  // Storage has no reset; only the pointers and count are cleared.
  always_ff @(posedge clk_fifo_i) begin
    if (!reset && !flush && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_fifo_i) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      LD_fifo_done <= 1'b0;
      RD_fifo_done <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      LD_fifo_done <= 1'b0;
      RD_fifo_done <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
      LD_fifo_done <= wr_acc;
      RD_fifo_done <= rd_acc;
      overflow     <= load & ~wr_acc;
      underflow    <= read & ~rd_acc;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (DEPTH=8): directed stimulus queues expected
// read words; a negedge monitor compares data_out on every RD_fifo_done pulse.
module tb_fifo_sync_param;

  logic       clk_fifo_i = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       load = 1'b0;
  logic       read = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       LD_fifo_done, RD_fifo_done;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  always #5 clk_fifo_i = ~clk_fifo_i;

  fifo_sync_param #(
    .DATA_W  (8),
    .DEPTH   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk_fifo_i  (clk_fifo_i),
    .reset       (reset),
    .flush       (flush),
    .load        (load),
    .read        (read),
    .data_in     (data_in),
    .data_out    (data_out),
    .LD_fifo_done(LD_fifo_done),
    .RD_fifo_done(RD_fifo_done),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of strobes; returns 1 time unit after the edge.
  task automatic step(input logic l, input logic r, input logic [7:0] d);
    load    = l;
    read    = r;
    data_in = d;
    @(posedge clk_fifo_i);
    #1;
    load = 1'b0;
    read = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_data_out", data_out, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_pulses", {LD_fifo_done, RD_fifo_done, overflow, underflow}, 0);
  endtask

  // Monitor: every read-done pulse must present the next queued word.
  always @(negedge clk_fifo_i) begin
    if (RD_fifo_done) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        chk("rd_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h5C);
    chk_reset_state();
    reset = 1'b0;

    // Fill with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
      chk("fill_count", count, i + 1);
      chk("fill_ld_done", LD_fifo_done, 1);
      chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 7) ? 1 : 0);
    end

    // Load while full
    step(1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_ld_done", LD_fifo_done, 0);
    chk("ovf_count", count, 8);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", overflow, 0);

    // Drain all eight, then one extra read
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h11 * (i + 1)));
      step(1'b0, 1'b1, 8'h00);
      chk("drain_count", count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    step(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", underflow, 1);
    chk("udf_rd_done", RD_fifo_done, 0);
    chk("udf_data_hold", data_out, 8'h88);

    // Refill with A0..A7, then simultaneous access at count 8
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    chk("refill_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'hA0 + i));
      step(1'b1, 1'b1, 8'(8'hB0 + i));
      chk("rw8_count", count, 8);
      chk("rw8_done", {LD_fifo_done, RD_fifo_done}, 2'b11);
    end
    // Contents now A4..A7,B0..B3; drain to count 3
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'hA4 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    exp_q.push_back(8'hB0);
    step(1'b0, 1'b1, 8'h00);
    chk("rw3_pre_count", count, 3);
    // Contents B1..B3; simultaneous access at count 3 through the wrap
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'hB1 + i));
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hC0 + i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'(8'hC0 + i));
      chk("rw3_count", count, 3);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'hC5 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("wrap_empty", empty, 1);

    // Load+read on empty: read rejected, write accepted
    step(1'b1, 1'b1, 8'h5A);
    chk("e_rw_udf", underflow, 1);
    chk("e_rw_ld_done", LD_fifo_done, 1);
    chk("e_rw_rd_done", RD_fifo_done, 0);
    chk("e_rw_count", count, 1);

    // Build to count 5 with data_out = 0x5A, then flush
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h61 + i));
    exp_q.push_back(8'h5A);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h65);
    chk("pre_flush_count", count, 5);
    chk("pre_flush_ae", almost_empty, 0);
    flush = 1'b1;
    step(1'b1, 1'b1, 8'h77);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_data_hold", data_out, 8'h5A);
    chk("flush_pulses", {LD_fifo_done, RD_fifo_done, overflow, underflow}, 0);
    step(1'b1, 1'b0, 8'h99);
    exp_q.push_back(8'h99);
    step(1'b0, 1'b1, 8'h00);
    chk("post_flush_empty", empty, 1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h31 + i));
    exp_q.push_back(8'h31);
    step(1'b0, 1'b1, 8'h00);
    reset = 1'b1;
    step(1'b1, 1'b1, 8'h3F);
    reset = 1'b0;
    chk_reset_state();
    step(1'b1, 1'b0, 8'h42);
    exp_q.push_back(8'h42);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_empty", empty, 1);

    step(1'b0, 1'b0, 8'h00);
    @(negedge clk_fifo_i);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
